// File: rtl/button_debounce_array_if.sv
// Pin-side and control-side signal bundle for the button debouncer.
// The raw pins flow in. Debounced level, press, release and repeat flow out.
// The release and repeat pulses carry a _pulse suffix because "release" and
// "repeat" are reserved words in SystemVerilog.
interface button_debounce_array_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] button_in;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] repeat_pulse;

  // Board / stimulus side: drives the pins and observes the debounced results.
  modport master (
    output button_in,
    input  level,
    input  press,
    input  release_pulse,
    input  repeat_pulse
  );

  // Debouncer side: samples the pins and produces the debounced results.
  modport slave (
    input  button_in,
    output level,
    output press,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/button_debounce_array.sv
// N-channel push-button debouncer.
// Each channel has the following stages:
//   - a 2-FF synchronizer;
//   - a saturating up/down integrator;
//   - a hysteresis level register;
//   - press and release edge pulses;
//   - an IDLE/DELAY/RATE auto-repeat FSM.
// The channels are fully independent. All outputs are registered.
module button_debounce_array #(
  parameter int N_BTN        = 5,
  parameter int CNT_W        = 16,
  parameter int HI_TH        = 49152,
  parameter int LO_TH        = 16384,
  parameter int RPT_W        = 24,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic                   clk,
  input  logic                   rst,
  button_debounce_array_if.slave bus
);

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RATE  = 2'd2
  } rpt_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HI_C     = CNT_W'(HI_TH);
  localparam logic [CNT_W-1:0] LO_C     = CNT_W'(LO_TH);

  localparam logic [RPT_W-1:0] RCNT_ZERO = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RCNT_ONE  = {{(RPT_W-1){1'b0}}, 1'b1};
  localparam logic [RPT_W-1:0] DELAY_C   = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RATE_C    = RPT_W'(REPEAT_RATE);

  // A zero first-repeat delay turns the repeat feature off entirely.
  localparam bit RPT_EN = (REPEAT_DELAY != 0);

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] repeat_q, repeat_d;

  logic [CNT_W-1:0] cnt_q  [N_BTN];
  logic [CNT_W-1:0] cnt_d  [N_BTN];
  logic [RPT_W-1:0] rcnt_q [N_BTN];
  logic [RPT_W-1:0] rcnt_d [N_BTN];
  rpt_state_t       state_q[N_BTN];
  rpt_state_t       state_d[N_BTN];

  // Synchronizer chain: the integrator sees the pins two edges late.
  always_comb begin
    sync1_d = bus.button_in;
    sync2_d = sync1_q;
  end

  // Integrator and hysteresis level.
  // The level is decided from the registered count, so it lags the count by one edge.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (!sync2_q[i] && (cnt_q[i] != CNT_ZERO)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end

      if (cnt_q[i] >= HI_C) begin
        level_d[i] = 1'b1;
      end else if (cnt_q[i] <= LO_C) begin
        level_d[i] = 1'b0;
      end else begin
        level_d[i] = level_q[i];
      end
    end
  end

  // Edge pulses are derived from the next level, so they register together with the level change.
  always_comb begin
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Auto-repeat FSM.
  // A falling level overrides everything, so a release never coincides with a repeat.
  always_comb begin
    repeat_d = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (!level_d[i]) begin
        state_d[i] = RPT_IDLE;
        rcnt_d[i]  = RCNT_ZERO;
      end else begin
        case (state_q[i])
          RPT_IDLE: begin
            if (RPT_EN && press_d[i]) begin
              state_d[i] = RPT_DELAY;
              rcnt_d[i]  = RCNT_ONE;
            end else begin
              state_d[i] = RPT_IDLE;
            end
          end
          RPT_DELAY: begin
            if (rcnt_q[i] == DELAY_C) begin
              state_d[i]  = RPT_RATE;
              rcnt_d[i]   = RCNT_ONE;
              repeat_d[i] = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RCNT_ONE;
            end
          end
          RPT_RATE: begin
            if (rcnt_q[i] == RATE_C) begin
              rcnt_d[i]   = RCNT_ONE;
              repeat_d[i] = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RCNT_ONE;
            end
          end
          default: begin
            state_d[i] = RPT_IDLE;
            rcnt_d[i]  = RCNT_ZERO;
          end
        endcase
      end
    end
  end

  // State registers: an asynchronous reset clears everything without emitting a release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= {N_BTN{1'b0}};
      sync2_q   <= {N_BTN{1'b0}};
      level_q   <= {N_BTN{1'b0}};
      press_q   <= {N_BTN{1'b0}};
      release_q <= {N_BTN{1'b0}};
      repeat_q  <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]   <= CNT_ZERO;
        rcnt_q[i]  <= RCNT_ZERO;
        state_q[i] <= RPT_IDLE;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i]   <= cnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;

endmodule
